// File: rtl/regfile_scan_pkg.sv
// Shared widths and FSM state encoding for the register-file scan checker.
package regfile_scan_pkg;
    localparam int REG_IDX_W = 5;
    localparam int COUNT_W   = 6;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        COMPARE,
        DONE
    } state_t;
endpackage

// File: rtl/rsc_expected_table.sv
// Expected-value table: per-entry data plus a check-mask bit, read combinationally by index.
module rsc_expected_table
    import regfile_scan_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_allow,
    input  logic                 exp_we,
    input  logic [REG_IDX_W-1:0] exp_addr,
    input  logic [DATA_W-1:0]    exp_data,
    input  logic                 exp_clear,
    input  logic [REG_IDX_W-1:0] rd_idx,
    output logic [DATA_W-1:0]    exp_val,
    output logic                 exp_mask
);
    logic [NUM_REGS-1:0] mask;
    logic [DATA_W-1:0]   mem [NUM_REGS];

    // Clear beats a same-cycle write so the entry stays unmasked.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            mask <= '0;
        else if (wr_allow && exp_clear)
            mask <= '0;
        else if (wr_allow && exp_we)
            mask[exp_addr] <= 1'b1;
    end

    // Data needs no reset: an entry is only consulted once its mask bit is set.
    always_ff @(posedge clock) begin
        if (wr_allow && exp_we && !exp_clear)
            mem[exp_addr] <= exp_data;
    end

    assign exp_val  = mem[rd_idx];
    assign exp_mask = mask[rd_idx];
endmodule

// File: rtl/regfile_scan_checker.sv
// Walks the register file through the skeleton test port and checks it against an expected table.
// Optional RSC_FAIL_MAP_EN adds a per-register mismatch bitmap on fail_map.
module regfile_scan_checker
    import regfile_scan_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 exp_we,
    input  logic [REG_IDX_W-1:0] exp_addr,
    input  logic [DATA_W-1:0]    exp_data,
    input  logic                 exp_clear,
    input  logic                 start,
    input  logic [DATA_W-1:0]    rd_data,
    output logic                 test_en,
    output logic [REG_IDX_W-1:0] read_reg,
    output logic                 busy,
    output logic                 done,
    output logic [COUNT_W-1:0]   pass_count,
    output logic [COUNT_W-1:0]   fail_count,
    output logic [REG_IDX_W-1:0] first_fail_reg,
    output logic [DATA_W-1:0]    first_fail_actual,
    output logic [NUM_REGS-1:0]  fail_map
);
    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;

    state_t               state, nstate;
    logic [REG_IDX_W-1:0] idx;
    logic [LAT_W-1:0]     wcnt;
    logic [DATA_W-1:0]    exp_val;
    logic                 exp_mask;
    logic                 last, scan_start, mismatch;

    rsc_expected_table #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_table (
        .clock    (clock),
        .reset    (reset),
        .wr_allow (!busy),
        .exp_we   (exp_we),
        .exp_addr (exp_addr),
        .exp_data (exp_data),
        .exp_clear(exp_clear),
        .rd_idx   (idx),
        .exp_val  (exp_val),
        .exp_mask (exp_mask)
    );

    assign last       = (idx == REG_IDX_W'(NUM_REGS - 1));
    assign scan_start = ((state == IDLE) || (state == DONE)) && start;
    assign mismatch   = (rd_data != exp_val);
    assign busy       = (state == ISSUE) || (state == WAIT) || (state == COMPARE);
    assign test_en    = busy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start) nstate = ISSUE;
            DONE:    nstate = start ? ISSUE : IDLE;
            ISSUE:   if (exp_mask) nstate = WAIT;
                     else if (last) nstate = DONE;
            WAIT:    if (wcnt == LAT_W'(READ_LAT - 1)) nstate = COMPARE;
            COMPARE: nstate = last ? DONE : ISSUE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx               <= '0;
            wcnt              <= '0;
            read_reg          <= '0;
            done              <= 1'b0;
            pass_count        <= '0;
            fail_count        <= '0;
            first_fail_reg    <= '0;
            first_fail_actual <= '0;
        end else if (scan_start) begin
            idx               <= '0;
            done              <= 1'b0;
            pass_count        <= '0;
            fail_count        <= '0;
            first_fail_reg    <= '0;
            first_fail_actual <= '0;
        end else begin
            case (state)
                ISSUE: begin
                    if (exp_mask) begin
                        read_reg <= idx;
                        wcnt     <= '0;
                    end else if (last) begin
                        done <= 1'b1;
                    end else begin
                        idx <= idx + REG_IDX_W'(1);
                    end
                end
                WAIT: wcnt <= wcnt + LAT_W'(1);
                COMPARE: begin
                    if (mismatch) begin
                        fail_count <= fail_count + COUNT_W'(1);
                        if (fail_count == '0) begin
                            first_fail_reg    <= idx;
                            first_fail_actual <= rd_data;
                        end
                    end else begin
                        pass_count <= pass_count + COUNT_W'(1);
                    end
                    if (last) done <= 1'b1;
                    else      idx  <= idx + REG_IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef RSC_FAIL_MAP_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            fail_map <= '0;
        else if (scan_start)
            fail_map <= '0;
        else if (state == COMPARE && mismatch)
            fail_map[idx] <= 1'b1;
    end
`else
    assign fail_map = '0;
`endif
endmodule

// File: tb/tb_regfile_scan_checker.sv
// Randomized self-checking bench for regfile_scan_checker against a table-walk reference model.
module tb_regfile_scan_checker;
    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int READ_LAT = 1;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              exp_we = 1'b0;
    logic [4:0]        exp_addr = '0;
    logic [DATA_W-1:0] exp_data = '0;
    logic              exp_clear = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              test_en, busy, done;
    logic [4:0]        read_reg, first_fail_reg;
    logic [5:0]        pass_count, fail_count;
    logic [DATA_W-1:0] first_fail_actual;
    logic [NUM_REGS-1:0] fail_map;

    regfile_scan_checker #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
        .clock(clock), .reset(reset), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_data(exp_data), .exp_clear(exp_clear), .start(start), .rd_data(rd_data),
        .test_en(test_en), .read_reg(read_reg), .busy(busy), .done(done),
        .pass_count(pass_count), .fail_count(fail_count), .first_fail_reg(first_fail_reg),
        .first_fail_actual(first_fail_actual), .fail_map(fail_map)
    );

    always #5 clock = ~clock;

    // Skeleton register file with a one-cycle test read port
    logic [DATA_W-1:0] rf [NUM_REGS];
    always @(posedge clock) rd_data <= rf[read_reg];

    logic [DATA_W-1:0] m_exp [NUM_REGS];
    bit                m_mask [NUM_REGS];
    int checks = 0;
    int failures = 0;

    int                  e_pass, e_fail, e_ffr, e_cyc;
    logic [DATA_W-1:0]   e_ffa;
    logic [NUM_REGS-1:0] e_map;

    // Reference: walk the table, tally results and the cycle cost of the scan
    task automatic model();
        e_pass = 0; e_fail = 0; e_ffr = 0; e_ffa = '0; e_map = '0; e_cyc = 1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (m_mask[i]) begin
                e_cyc += 2 + READ_LAT;
                if (rf[i] == m_exp[i]) e_pass++;
                else begin
                    if (e_fail == 0) begin e_ffr = i; e_ffa = rf[i]; end
                    e_fail++;
                    e_map[i] = 1'b1;
                end
            end else begin
                e_cyc += 1;
            end
        end
`ifndef RSC_FAIL_MAP_EN
        e_map = '0;
`endif
    endtask

    task automatic wr_exp(input int a, input logic [DATA_W-1:0] d);
        @(negedge clock);
        exp_we = 1'b1; exp_addr = a[4:0]; exp_data = d;
        @(negedge clock);
        exp_we = 1'b0;
        m_exp[a] = d; m_mask[a] = 1'b1;
    endtask

    task automatic clear_tbl();
        @(negedge clock);
        exp_clear = 1'b1;
        @(negedge clock);
        exp_clear = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) m_mask[i] = 1'b0;
    endtask

    // Pulses start and counts rising edges (sampling edge included) until done; -1 on timeout
    task automatic run_scan(output int cyc);
        @(negedge clock);
        start = 1'b1;
        cyc = 0;
        while (cyc < 400) begin
            @(posedge clock); cyc++; #1;
            start = 1'b0;
            if (done) break;
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({test_en, busy, done, read_reg, pass_count, fail_count, first_fail_reg,
             first_fail_actual, fail_map} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b pass=%0d fail=%0d ffr=%0d map=%h, want all 0",
                     busy, done, pass_count, fail_count, first_fail_reg, fail_map);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int cyc;
        for (int i = 0; i < NUM_REGS; i++) rf[i] = $urandom;
        rf[1] = 65535; rf[2] = 3;
        wr_exp(1, 65535);
        wr_exp(2, 3);
        run_scan(cyc);
        checks++;
        if (cyc !== 37) begin failures++; $display("FAIL basic_latency: got %0d want 37", cyc); end
        checks++;
        if (pass_count !== 6'd2 || fail_count !== 6'd0 || first_fail_reg !== 5'd0 || first_fail_actual !== '0) begin
            failures++;
            $display("FAIL basic_counts: got pass=%0d fail=%0d ffr=%0d ffa=%0d want 2/0/0/0",
                     pass_count, fail_count, first_fail_reg, first_fail_actual);
        end
        checks++;
        if (test_en !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_done_idle: got test_en=%b busy=%b want 0/0", test_en, busy);
        end
    endtask

    task automatic test_single_fail();
        int cyc;
        logic [NUM_REGS-1:0] want_map;
        for (int i = 0; i < NUM_REGS; i++) begin rf[i] = i; wr_exp(i, i); end
        rf[5] = 99;
        run_scan(cyc);
`ifdef RSC_FAIL_MAP_EN
        want_map = 32'h0000_0020;
`else
        want_map = '0;
`endif
        checks++;
        if (cyc !== 97) begin failures++; $display("FAIL single_latency: got %0d want 97", cyc); end
        checks++;
        if (pass_count !== 6'd31 || fail_count !== 6'd1 || first_fail_reg !== 5'd5 || first_fail_actual !== 99) begin
            failures++;
            $display("FAIL single_counts: got pass=%0d fail=%0d ffr=%0d ffa=%0d want 31/1/5/99",
                     pass_count, fail_count, first_fail_reg, first_fail_actual);
        end
        checks++;
        if (fail_map !== want_map) begin
            failures++; $display("FAIL single_map: got %h want %h", fail_map, want_map);
        end
    endtask

    task automatic test_random();
        int cyc;
        for (int it = 0; it < 4; it++) begin
            clear_tbl();
            for (int i = 0; i < NUM_REGS; i++) begin
                if ($urandom_range(1, 0) == 1) wr_exp(i, $urandom);
                if (m_mask[i] && $urandom_range(2, 0) != 0) rf[i] = m_exp[i];
                else rf[i] = $urandom;
            end
            model();
            run_scan(cyc);
            checks++;
            if (cyc !== e_cyc) begin failures++; $display("FAIL rand%0d_latency: got %0d want %0d", it, cyc, e_cyc); end
            checks++;
            if (pass_count !== e_pass[5:0] || fail_count !== e_fail[5:0]) begin
                failures++;
                $display("FAIL rand%0d_counts: got pass=%0d fail=%0d want %0d/%0d", it, pass_count, fail_count, e_pass, e_fail);
            end
            checks++;
            if (first_fail_reg !== e_ffr[4:0] || first_fail_actual !== e_ffa) begin
                failures++;
                $display("FAIL rand%0d_first: got reg=%0d val=%h want %0d/%h", it, first_fail_reg, first_fail_actual, e_ffr, e_ffa);
            end
            checks++;
            if (fail_map !== e_map) begin
                failures++; $display("FAIL rand%0d_map: got %h want %h", it, fail_map, e_map);
            end
        end
    endtask

    task automatic test_write_while_busy();
        int cyc, n;
        clear_tbl();
        wr_exp(3, 32'h33);
        rf[3] = 32'h33; rf[7] = 32'h7;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        n = 0;
        while (!(test_en && read_reg == 5'd3) && n < 50) begin @(negedge clock); n++; end
        checks++;
        if (n >= 50) begin failures++; $display("FAIL busy_reach_wait: got timeout want read_reg=3"); end
        exp_we = 1'b1; exp_addr = 5'd7; exp_data = 32'h7;
        @(negedge clock);
        exp_we = 1'b0;
        n = 0;
        while (!done && n < 100) begin @(negedge clock); n++; end
        run_scan(cyc);
        checks++;
        if (cyc !== 35 || pass_count !== 6'd1 || fail_count !== 6'd0) begin
            failures++;
            $display("FAIL busy_write_dropped: got cyc=%0d pass=%0d fail=%0d want 35/1/0", cyc, pass_count, fail_count);
        end
    endtask

    task automatic test_reset_mid_scan();
        int cyc, n;
        for (int i = 0; i < NUM_REGS; i++) begin rf[i] = i; wr_exp(i, i); end
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        n = 0;
        while (!(test_en && read_reg == 5'd10) && n < 100) begin @(negedge clock); n++; end
        @(negedge clock);
        checks++;
        if (n >= 100 || pass_count !== 6'd10 || busy !== 1'b1) begin
            failures++; $display("FAIL midscan_position: got pass=%0d busy=%b want 10/1", pass_count, busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({test_en, busy, done, pass_count, fail_count} !== '0) begin
            failures++;
            $display("FAIL midscan_abort: got test_en=%b busy=%b pass=%0d fail=%0d want 0", test_en, busy, pass_count, fail_count);
        end
        #2 reset = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) m_mask[i] = 1'b0;
        run_scan(cyc);
        checks++;
        if (cyc !== 33 || pass_count !== 6'd0 || fail_count !== 6'd0) begin
            failures++;
            $display("FAIL midscan_mask_empty: got cyc=%0d pass=%0d fail=%0d want 33/0/0", cyc, pass_count, fail_count);
        end
    endtask

    task automatic test_start_held();
        int c1, c2;
        for (int i = 0; i < NUM_REGS; i++) begin rf[i] = i; if (i % 3 == 0) wr_exp(i, i); end
        rf[9] = 32'hdead; rf[30] = 32'h1;
        model();
        @(negedge clock); start = 1'b1;
        c1 = 0;
        while (c1 < 400) begin @(posedge clock); c1++; #1; if (done) break; end
        checks++;
        if (c1 !== e_cyc || pass_count !== e_pass[5:0] || fail_count !== e_fail[5:0]) begin
            failures++;
            $display("FAIL held_first: got cyc=%0d pass=%0d fail=%0d want %0d/%0d/%0d", c1, pass_count, fail_count, e_cyc, e_pass, e_fail);
        end
        @(posedge clock); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || pass_count !== 6'd0 || fail_count !== 6'd0) begin
            failures++;
            $display("FAIL held_restart: got done=%b busy=%b pass=%0d fail=%0d want 0/1/0/0", done, busy, pass_count, fail_count);
        end
        c2 = 1;
        while (c2 < 400) begin @(posedge clock); c2++; #1; if (done) break; end
        start = 1'b0;
        checks++;
        if (c2 !== e_cyc || pass_count !== e_pass[5:0] || fail_count !== e_fail[5:0] || first_fail_reg !== e_ffr[4:0]) begin
            failures++;
            $display("FAIL held_second: got cyc=%0d pass=%0d fail=%0d ffr=%0d want %0d/%0d/%0d/%0d",
                     c2, pass_count, fail_count, first_fail_reg, e_cyc, e_pass, e_fail, e_ffr);
        end
        @(posedge clock); #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL held_idle: got done=%b busy=%b want 1/0", done, busy);
        end
    endtask

    task automatic test_clear_wins();
        int cyc;
        @(negedge clock);
        exp_clear = 1'b1; exp_we = 1'b1; exp_addr = 5'd4; exp_data = 32'h4;
        @(negedge clock);
        exp_clear = 1'b0; exp_we = 1'b0;
        run_scan(cyc);
        checks++;
        if (cyc !== 33 || pass_count !== 6'd0 || fail_count !== 6'd0) begin
            failures++;
            $display("FAIL clear_wins: got cyc=%0d pass=%0d fail=%0d want 33/0/0", cyc, pass_count, fail_count);
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) begin rf[i] = '0; m_exp[i] = '0; m_mask[i] = 1'b0; end
        test_reset();
        test_basic();
        test_single_fail();
        test_random();
        test_write_while_busy();
        test_reset_mid_scan();
        test_start_held();
        test_clear_wins();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/regfile_scan_checker.md
Name: regfile_scan_checker

Overview:
- Downstream consumer of the processor skeleton's test read port.
- Once the processor run is finished, it takes over the register file through the skeleton's test mux. It walks every register index, compares each read-back value against a preloaded expected table, and reports pass/fail counts plus first-failure details.
- Replaces per-register bench tasks with a synthesizable, reusable scan engine usable on board and in simulation.

Parameters:
- NUM_REGS, 32, number of register indices scanned (0..NUM_REGS-1)
- DATA_W, 32, register data width
- READ_LAT, 1, cycles from read_reg change to valid rd_data (>=1)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- exp_we  in  1  write one expected-table entry
- exp_addr  in  5  register index for expected entry
- exp_data  in  DATA_W  expected value
- exp_clear  in  1  clears all check-mask bits
- start  in  1  begin scan (level sampled on rising edge)
- rd_data  in  DATA_W  skeleton test read-port data (readRegA)
- test_en  out  1  drives skeleton "test" select; high only while scanning
- read_reg  out  5  drives skeleton test readRegA index
- busy  out  1  scan in progress
- done  out  1  scan complete; held until next start or reset
- pass_count  out  6  checked registers that matched
- fail_count  out  6  checked registers that mismatched
- first_fail_reg  out  5  index of first mismatch (0 if none)
- first_fail_actual  out  DATA_W  read-back value at first mismatch (0 if none)
- fail_map  out  NUM_REGS  per-register mismatch bitmap (see Optional Feature)

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all outputs 0; check mask cleared.
  - Expected data contents are don't-care.
  - Reset mid-scan aborts immediately; test_en drops asynchronously.
- Expected table: NUM_REGS x DATA_W plus a 1-bit check mask per entry.
  - exp_we in IDLE/DONE: writes data and sets the mask bit.
  - exp_clear clears all mask bits; it wins over a same-cycle exp_we.
  - exp_we/exp_clear while busy: dropped, table unchanged.
- FSM states: IDLE, ISSUE, WAIT, COMPARE, DONE.
  - IDLE/DONE + start=1 -> ISSUE with idx=0. Entering ISSUE from IDLE/DONE clears counts, first_fail fields, fail_map and done.
  - ISSUE, mask[idx]=0: register skipped, 1 cycle, no count change. idx==NUM_REGS-1 -> DONE, else idx+1 and stay in ISSUE.
  - ISSUE, mask[idx]=1: read_reg=idx -> WAIT.
  - WAIT: lasts READ_LAT cycles, then -> COMPARE.
  - COMPARE: samples rd_data, compares against exp[idx], then advances as for the skipped case.
  - Cycle cost: checked register 2+READ_LAT cycles; skipped register 1 cycle.
- test_en=busy=1 in ISSUE/WAIT/COMPARE; 0 in IDLE/DONE.
- read_reg holds the last issued index until the next issue; reset value 0.
- Compare result:
  - Match: pass_count+1.
  - Mismatch: fail_count+1. If this is the first mismatch of the scan, latch first_fail_reg=idx and first_fail_actual=rd_data.
- Counts are 6-bit and cannot overflow for NUM_REGS<=32 (max 32).
- start held high through DONE: DONE lasts exactly 1 cycle, then a rescan begins. start in ISSUE/WAIT/COMPARE is ignored.
- done=1 in DONE and remains 1 in IDLE after return; cleared on next scan start.
  - DONE -> IDLE when start=0.
- Register 0 is checked like any other index if its mask bit is set.

Optional Feature:
- Macro RSC_FAIL_MAP_EN.
- Defined: fail_map[idx] set on mismatch in COMPARE; cleared on scan start and reset.
- Undefined: fail_map tied to 0; no bitmap flops synthesized.
- All other behaviour identical in both builds.

Decomposition:
- Shared package regfile_scan_pkg:
  - REG_IDX_W=5, COUNT_W=6
  - state enum/localparams for IDLE/ISSUE/WAIT/COMPARE/DONE
- One natural sub-module: rsc_expected_table (mask + data storage, write/clear logic, combinational read by idx).
- FSM, counters and result capture stay in the top module.

Test Plan:
- Load exp[1]=65535, exp[2]=3 (mask only 1,2); regfile r1=65535, r2=3; start pulse.
  - pass_count=2, fail_count=0, first_fail_reg=0.
  - done rises 1+30+2*(2+1)=37 cycles after the start edge (READ_LAT=1).
- Load all 32 entries = index value; regfile r5 holds 99, others correct.
  - pass_count=31, fail_count=1, first_fail_reg=5, first_fail_actual=99.
  - With RSC_FAIL_MAP_EN: fail_map=32'h0000_0020.
- exp_we to index 7 during WAIT, then rescan: entry 7 unchanged and still unmasked, so no count for r7.
- Assert reset=0 mid-COMPARE of index 10: test_en/busy/counts drop to 0 at once; after release, state is IDLE and the mask is empty.
- start held high continuously: done pulses 1 cycle in DONE, a new scan begins, counts clear and re-accumulate to the same values.
- exp_clear and exp_we same cycle, then start: zero registers checked; done after 33 cycles; pass_count=fail_count=0.
